// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package seq_multiplier_pkg;

    // Default operand width; the product is twice this wide.
    localparam int DEFAULT_WIDTH = 16;

    // Controller states; encoding 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_multiplier_adder.sv
// Plain unsigned ripple adder shared by the ALU datapath; carry-out is dropped.
module nbit_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o
);

    // Modulo-2^WIDTH sum; callers guarantee no overflow.
    always_comb begin
        sum_o = a_i + b_i;
    end

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle unsigned shift-add multiplier: one partial product per cycle
// through a single shared adder, fixed latency of WIDTH+1 cycles to done.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplr_q, mplr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    product_q, product_d;
    logic             busy_q;
    logic             done_q;
    logic [PW-1:0]    sum;

    // The only adder in the block: accumulator plus shifted multiplicand.
    nbit_adder #(
        .WIDTH(PW)
    ) u_adder (
        .a_i  (acc_q),
        .b_i  (mcand_q),
        .sum_o(sum)
    );

    // Next-state logic for the controller and the shift/accumulate datapath.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = {{WIDTH{1'b0}}, a};
                    mplr_d  = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d   = mplr_q[0] ? sum : acc_q;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                // Last partial product: publish the final accumulator value.
                if (cnt_q == CNT_LAST) begin
                    product_d = acc_d;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; busy/done are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplr_q    <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplr_q    <= mplr_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= (state_d != S_IDLE);
            done_q    <= (state_d == S_DONE);
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and randomized bench for seq_multiplier at WIDTH=16 and WIDTH=4.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, busy, done;
    logic [15:0] a, b;
    logic [31:0] product;
    logic        start4, busy4, done4;
    logic [3:0]  a4, b4;
    logic [7:0]  product4;

    int npass  = 0;
    int nfail  = 0;
    int ntotal = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .product(product)
    );

    seq_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .product(product4)
    );

    // Reference: the product is simply the arithmetic product of the operands.
    function automatic logic [63:0] ref_mul(input longint unsigned x, input longint unsigned y);
        return 64'(x * y);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntotal++;
        assert (obs === exp) npass = npass + 1;
        else begin
            nfail = nfail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Move to one time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full 16-bit operation with latency checks; entered in cycle c.
    task automatic mul16(input logic [15:0] x, input logic [15:0] y, input string tag);
        logic seen;
        a = x; b = y; start = 1'b1;
        step();                               // c+1
        start = 1'b0;
        chk({tag, " busy_c1"}, 64'(busy), 64'd1);
        seen = 1'b0;
        for (int i = 2; i <= 16; i++) begin
            step();
            seen = seen | done;
        end
        chk({tag, " early_done"}, 64'(seen), 64'd0);
        step();                               // c+17
        chk({tag, " done_c17"}, 64'(done), 64'd1);
        chk({tag, " product"}, 64'(product), ref_mul(x, y));
        step();                               // c+18
        chk({tag, " idle_c18"}, 64'({busy, done}), 64'd0);
    endtask

    task automatic mul4(input logic [3:0] x, input logic [3:0] y, input string tag);
        logic seen;
        a4 = x; b4 = y; start4 = 1'b1;
        step();                               // c+1
        start4 = 1'b0;
        chk({tag, " busy_c1"}, 64'(busy4), 64'd1);
        seen = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            step();
            seen = seen | done4;
        end
        chk({tag, " early_done"}, 64'(seen), 64'd0);
        step();                               // c+5
        chk({tag, " done_c5"}, 64'(done4), 64'd1);
        chk({tag, " product"}, 64'(product4), ref_mul(x, y));
        step();
        chk({tag, " idle_c6"}, 64'({busy4, done4}), 64'd0);
    endtask

    initial begin
        logic seen;
        int   n;
        int   pos[3];

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        step();
        step();
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_product", 64'(product), 64'd0);
        chk("reset_w4", 64'({busy4, done4, product4}), 64'd0);

        // Start coincident with reset is dropped.
        rst = 1'b1; start = 1'b1; a = 16'd9; b = 16'd9;
        step();
        rst = 1'b0; start = 1'b0;
        step();
        chk("start_with_rst", 64'(busy), 64'd0);

        // Basic and full-scale operands.
        mul16(16'd138, 16'd299, "basic");
        chk("basic_const", 64'(product), 64'd41262);
        mul16(16'hFFFF, 16'hFFFF, "full");
        chk("full_const", 64'(product), 64'hFFFE_0001);
        mul16(16'h0000, 16'hFFFF, "zero");
        mul16(16'd1, 16'hFFFF, "one");

        // Start in RUN and DONE is ignored.
        a = 16'd138; b = 16'd299; start = 1'b1;
        step();                               // c+1
        start = 1'b0;
        repeat (4) step();                    // c+5
        a = 16'd5; b = 16'd7; start = 1'b1;
        step();
        start = 1'b0;
        seen = 1'b0;
        for (int i = 7; i <= 16; i++) begin
            step();
            seen = seen | done;
        end
        chk("ign early_done", 64'(seen), 64'd0);
        step();                               // c+17, DONE
        chk("ign done", 64'(done), 64'd1);
        chk("ign product", 64'(product), ref_mul(138, 299));
        start = 1'b1;
        step();                               // c+18
        start = 1'b0;
        chk("ign idle_c18", 64'({busy, done}), 64'd0);
        seen = 1'b0;
        repeat (20) begin
            step();
            seen = seen | done | busy;
        end
        chk("ign no_second_op", 64'(seen), 64'd0);

        // Back-to-back with start held high.
        a = 16'd72; b = 16'd29; start = 1'b1;
        n = 0;
        pos = '{0, 0, 0};
        for (int k = 1; k <= 70; k++) begin
            step();
            if (done) begin
                pos[n] = k;
                chk("b2b product", 64'(product), ref_mul(72, 29));
                n++;
                if (n == 3) begin
                    start = 1'b0;
                    break;
                end
            end
        end
        chk("b2b count", 64'(n), 64'd3);
        chk("b2b pos0", 64'(pos[0]), 64'd17);
        chk("b2b pos1", 64'(pos[1]), 64'd35);
        chk("b2b pos2", 64'(pos[2]), 64'd53);
        step();
        step();
        chk("b2b idle", 64'(busy), 64'd0);

        // Reset mid-operation aborts and clears the product.
        a = 16'd138; b = 16'd299; start = 1'b1;
        step();                               // c+1
        start = 1'b0;
        repeat (7) step();                    // c+8
        rst = 1'b1;
        step();                               // c+9
        rst = 1'b0;
        chk("rst_mid busy", 64'(busy), 64'd0);
        chk("rst_mid done", 64'(done), 64'd0);
        chk("rst_mid product", 64'(product), 64'd0);
        seen = 1'b0;
        repeat (25) begin
            step();
            seen = seen | done | busy;
        end
        chk("rst_mid no_done", 64'(seen), 64'd0);
        mul16(16'd3, 16'd4, "after_rst");
        chk("after_rst const", 64'(product), 64'd12);

        // Randomized operands against the reference.
        for (int i = 0; i < 6; i++) begin
            mul16(16'($urandom), 16'($urandom), "rand16");
        end

        // Narrow instance.
        mul4(4'd15, 4'd15, "w4_full");
        chk("w4_const", 64'(product4), 64'd225);
        for (int i = 0; i < 4; i++) begin
            mul4(4'($urandom), 4'($urandom), "rand4");
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
